// File: rtl/box_controller_multi.sv
// Multi-box on-screen controller: button-steered move/resize with
// edge clamping, size limits and press-and-hold auto-repeat.
module box_controller_multi #(
  parameter int IMAGE_WIDTH   = 1280,
  parameter int IMAGE_HEIGHT  = 720,
  parameter int COORD_W       = 12,
  parameter int NUM_BOXES     = 4,
  parameter int INIT_BOX_SIZE = 50,
  parameter int MIN_BOX_SIZE  = 5,
  parameter int MAX_BOX_SIZE  = 300,
  parameter int STEP_FAST     = 10,
  parameter int STEP_SLOW     = 2,
  parameter int HOLD_DELAY    = 50000000,
  parameter int REPEAT_DELAY  = 10000000,
  localparam int SW = (NUM_BOXES > 1) ? $clog2(NUM_BOXES) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mode_sel,
  input  logic                   speed_sel,
  input  logic [4:0]             butns,
  output logic [16*NUM_BOXES-1:0] x1_o,
  output logic [16*NUM_BOXES-1:0] x2_o,
  output logic [16*NUM_BOXES-1:0] y1_o,
  output logic [16*NUM_BOXES-1:0] y2_o,
  output logic [SW-1:0]          sel_o,
  output logic [1:0]             leds
);

  localparam int CW   = COORD_W;
  localparam int CNTW = $clog2(HOLD_DELAY + 1);
  localparam logic [CW-1:0] XMAX = CW'(IMAGE_WIDTH - 1);
  localparam logic [CW-1:0] YMAX = CW'(IMAGE_HEIGHT - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_RPT} state_t;

  logic [4:0]      r_s1, r_s2, r_prev;
  state_t          r_state;
  logic [CNTW-1:0] r_cnt;
  logic [SW-1:0]   r_sel;
  logic [1:0]      r_leds;
  logic [CW-1:0]   r_x1 [NUM_BOXES];
  logic [CW-1:0]   r_x2 [NUM_BOXES];
  logic [CW-1:0]   r_y1 [NUM_BOXES];
  logic [CW-1:0]   r_y2 [NUM_BOXES];

  logic [4:0]      w_rise;
  logic            w_dir, w_rdir, w_ctr, w_go, w_apply;
  logic [3:0]      w_mask;
  logic [CW-1:0]   w_step;
  logic [2*CW-1:0] w_nx, w_ny;

  function automatic logic [2*CW-1:0] f_axis(
    input logic [CW-1:0] lo, hi, lim, st,
    input logic rsz, dec, inc, grow, shrink
  );
    logic [CW-1:0] dl, dh, nl, nh;
    dl = (st < lo) ? st : lo;
    dh = (st < (lim - hi)) ? st : (lim - hi);
    f_axis = {lo, hi};
    if (!rsz) begin
      if (dec)      f_axis = {lo - dl, hi - dl};
      else if (inc) f_axis = {lo + dh, hi + dh};
    end else if (grow) begin
      nl = lo - dl;
      nh = hi + dh;
      if (nh - nl + ONE <= CW'(MAX_BOX_SIZE)) f_axis = {nl, nh};
    end else if (shrink) begin
      if (hi - lo + ONE >= CW'(MIN_BOX_SIZE) + (st << 1))
        f_axis = {lo + st, hi - st};
    end
  endfunction

  assign w_rise = r_s2 & ~r_prev;
  assign w_dir  = |r_s2[3:0];
  assign w_rdir = |w_rise[3:0];
  assign w_ctr  = w_rise[4];
  assign w_step = speed_sel ? CW'(STEP_SLOW) : CW'(STEP_FAST);

  // Fresh presses act on the new directions; repeats act on all held ones.
  always_comb begin
    w_go   = 1'b0;
    w_mask = 4'b0;
    if (w_rdir) begin
      w_go   = 1'b1;
      w_mask = w_rise[3:0];
    end else if (r_state != S_IDLE && w_dir && r_cnt == '0) begin
      w_go   = 1'b1;
      w_mask = r_s2[3:0];
    end
    if (r_s2[0] && r_s2[1]) w_mask[1:0] = 2'b00;
    if (r_s2[2] && r_s2[3]) w_mask[3:2] = 2'b00;
  end

  assign w_apply = w_go && !w_ctr;

  assign w_nx = f_axis(r_x1[r_sel], r_x2[r_sel], XMAX, w_step, mode_sel,
                       w_mask[0], w_mask[1], w_mask[1], w_mask[0]);
  assign w_ny = f_axis(r_y1[r_sel], r_y2[r_sel], YMAX, w_step, mode_sel,
                       w_mask[2], w_mask[3], w_mask[2], w_mask[3]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_prev  <= '0;
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sel   <= '0;
      r_leds  <= 2'b01;
    end else begin
      r_s1   <= butns;
      r_s2   <= r_s1;
      r_prev <= r_s2;
      r_leds <= mode_sel ? 2'b10 : 2'b01;
      if (w_ctr)
        r_sel <= (r_sel == SW'(NUM_BOXES - 1)) ? '0 : r_sel + SW'(1);
      unique case (r_state)
        S_IDLE: begin
          if (w_rdir) begin
            r_cnt   <= CNTW'(HOLD_DELAY - 1);
            r_state <= S_HOLD;
          end
        end
        S_HOLD, S_RPT: begin
          if (!w_dir) begin
            r_state <= S_IDLE;
          end else if (w_rdir) begin
            r_cnt   <= CNTW'(HOLD_DELAY - 1);
            r_state <= S_HOLD;
          end else if (r_cnt == '0) begin
            r_cnt   <= CNTW'(REPEAT_DELAY - 1);
            r_state <= S_RPT;
          end else begin
            r_cnt <= r_cnt - CNTW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_BOXES; i++) begin
        r_x1[i] <= CW'(i * INIT_BOX_SIZE);
        r_x2[i] <= CW'(i * INIT_BOX_SIZE + INIT_BOX_SIZE - 1);
        r_y1[i] <= '0;
        r_y2[i] <= CW'(INIT_BOX_SIZE - 1);
      end
    end else if (w_apply) begin
      r_x1[r_sel] <= w_nx[2*CW-1:CW];
      r_x2[r_sel] <= w_nx[CW-1:0];
      r_y1[r_sel] <= w_ny[2*CW-1:CW];
      r_y2[r_sel] <= w_ny[CW-1:0];
    end
  end

  for (genvar g = 0; g < NUM_BOXES; g++) begin : g_out
    assign x1_o[16*g +: 16] = {{(16-CW){1'b0}}, r_x1[g]};
    assign x2_o[16*g +: 16] = {{(16-CW){1'b0}}, r_x2[g]};
    assign y1_o[16*g +: 16] = {{(16-CW){1'b0}}, r_y1[g]};
    assign y2_o[16*g +: 16] = {{(16-CW){1'b0}}, r_y2[g]};
  end

  assign sel_o = r_sel;
  assign leds  = r_leds;

endmodule
